// File: rtl/output_scheduler.sv
// -----------------------------------------------------------------------------
// output_scheduler
//
// Purpose: collects finished 1600-bit states from four cores and streams each
// one out as eight consecutive 200-bit beats (beat k = state[200k+199:200k]),
// with the core's 8-bit tag alongside. A new block can start right after beat
// 7 of the previous one, so streaming is back-to-back with no idle cycles.
//
// Arbitration:
//   OUTPUT_SCHEDULER_RR_EN defined   -> round-robin. The search starts at the
//                                       core after the last grant and wraps
//                                       3->0.
//   OUTPUT_SCHEDULER_RR_EN undefined -> fixed priority, lowest index wins. The
//                                       last-grant pointer is still tracked.
//
// Ports:
//   i_clk                 single clock, rising edge
//   i_rst_n               asynchronous active-low reset
//   i_reqin[3:0]          core i has a result ready (held until o_ackout[i])
//   i_din0..i_din3        1600-bit result state of each core
//   i_tagin0..i_tagin3    8-bit tag of each core's result
//   o_ackout[3:0]         one-hot, one-cycle pulse: core i's result captured
//   o_dout[199:0]         current beat
//   o_doutix[2:0]         index of the beat on o_dout
//   o_pushout             o_dout/o_doutix/o_tagout valid this cycle
//   o_tagout[7:0]         tag of the block being emitted
//   o_busy                high while a block is being sent
// -----------------------------------------------------------------------------
module output_scheduler (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [3:0]    i_reqin,
    input  logic [1599:0] i_din0,
    input  logic [1599:0] i_din1,
    input  logic [1599:0] i_din2,
    input  logic [1599:0] i_din3,
    input  logic [7:0]    i_tagin0,
    input  logic [7:0]    i_tagin1,
    input  logic [7:0]    i_tagin2,
    input  logic [7:0]    i_tagin3,
    output logic [3:0]    o_ackout,
    output logic [199:0]  o_dout,
    output logic [2:0]    o_doutix,
    output logic          o_pushout,
    output logic [7:0]    o_tagout,
    output logic          o_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [1:0]      r_ptr;
    logic [1599:0]   r_cap;
    logic [7:0]      r_tag;
    logic [3:0]      r_ack;

    logic [1599:0]   w_din   [4];
    logic [7:0]      w_tagin [4];
    logic [199:0]    w_beat  [8];
    logic            w_grant_en;
    logic [1:0]      w_winner;

    assign w_din[0]   = i_din0;
    assign w_din[1]   = i_din1;
    assign w_din[2]   = i_din2;
    assign w_din[3]   = i_din3;
    assign w_tagin[0] = i_tagin0;
    assign w_tagin[1] = i_tagin1;
    assign w_tagin[2] = i_tagin2;
    assign w_tagin[3] = i_tagin3;

    // Slice the captured state into its eight beats.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_beat
            assign w_beat[gi] = r_cap[gi*200 +: 200];
        end
    endgenerate

    // Requests are only looked at while idle or on the last beat. This is what
    // makes the stream back-to-back, and it also means that request changes in
    // the middle of a block are ignored.
    assign w_grant_en = ((r_state == ST_IDLE) || (r_cnt == 3'd7)) && (i_reqin != 4'b0000);

`ifdef OUTPUT_SCHEDULER_RR_EN
    logic       w_found;
    logic [1:0] w_idx;

    // Scan from the core after the last grant. The 2-bit index wraps on its own.
    always_comb begin
        w_winner = 2'd0;
        w_found  = 1'b0;
        w_idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'd1 + 2'(k);
            if (!w_found && i_reqin[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end
`else
    // The pointer is maintained but has no effect on fixed priority.
    logic w_unused_ptr;
    assign w_unused_ptr = ^r_ptr;

    // Scan from the top down so that the lowest requesting index is the last
    // one written.
    always_comb begin
        w_winner = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (i_reqin[k]) begin
                w_winner = 2'(k);
            end
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_ptr   <= 2'd3;
            r_cap   <= '0;
            r_tag   <= 8'd0;
            r_ack   <= 4'b0000;
        end else begin
            r_ack <= 4'b0000;
            if (w_grant_en) begin
                r_cap   <= w_din[w_winner];
                r_tag   <= w_tagin[w_winner];
                r_ptr   <= w_winner;
                r_cnt   <= 3'd0;
                r_state <= ST_SEND;
                r_ack   <= 4'b0001 << w_winner;
            end else if (r_state == ST_SEND) begin
                // After beat 7 the counter wraps to 0, which is its idle value.
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    // The outputs are decoded only from registers that reset asynchronously,
    // so a reset takes them to zero immediately.
    always_comb begin
        o_ackout  = r_ack;
        o_pushout = (r_state == ST_SEND);
        o_busy    = (r_state == ST_SEND);
        o_doutix  = 3'd0;
        o_dout    = '0;
        o_tagout  = 8'd0;
        if (r_state == ST_SEND) begin
            o_doutix = r_cnt;
            o_dout   = w_beat[r_cnt];
            o_tagout = r_tag;
        end
    end

endmodule

// File: tb/tb_output_scheduler.sv
module tb_output_scheduler;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    reqin;
    logic [3:0]    sticky;
    logic [1599:0] din   [4];
    logic [7:0]    tagin [4];
    logic [3:0]    ackout;
    logic [199:0]  dout;
    logic [2:0]    doutix;
    logic          pushout;
    logic [7:0]    tagout;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    output_scheduler dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_reqin  (reqin),
        .i_din0   (din[0]),
        .i_din1   (din[1]),
        .i_din2   (din[2]),
        .i_din3   (din[3]),
        .i_tagin0 (tagin[0]),
        .i_tagin1 (tagin[1]),
        .i_tagin2 (tagin[2]),
        .i_tagin3 (tagin[3]),
        .o_ackout (ackout),
        .o_dout   (dout),
        .o_doutix (doutix),
        .o_pushout(pushout),
        .o_tagout (tagout),
        .o_busy   (busy)
    );

    // Each core streams a recognisable pattern. For core 0, beat k carries
    // the value k+1.
    function automatic logic [199:0] beat_val(input int c, input int k);
        return 200'(k + 1) | (200'(c) << 100);
    endfunction

    function automatic logic [7:0] tag_of(input int c);
        return 8'(8'h5A + c);
    endfunction

    function automatic int pick(input logic [3:0] r, input int ptr);
        int res;
        bit found;
        res   = 0;
        found = 0;
`ifdef OUTPUT_SCHEDULER_RR_EN
        for (int off = 1; off <= 4; off++) begin
            if (!found && r[(ptr + off) % 4]) begin
                res   = (ptr + off) % 4;
                found = 1;
            end
        end
`else
        for (int c = 0; c < 4; c++) begin
            if (!found && r[c]) begin
                res   = c;
                found = 1;
            end
        end
`endif
        return res;
    endfunction

    // Behavioural model. m_left is the number of beats of the current block
    // that are still to be shown. A new block may be taken only when nothing
    // or just the last beat remains.
    int m_left = 0;
    int m_core = 0;
    int m_ptr  = 3;
    int m_ack  = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_core <= 0;
            m_ptr  <= 3;
            m_ack  <= -1;
        end else if (m_left <= 1 && reqin != 4'b0000) begin
            m_left <= 8;
            m_core <= pick(reqin, m_ptr);
            m_ptr  <= pick(reqin, m_ptr);
            m_ack  <= pick(reqin, m_ptr);
        end else begin
            m_ack <= -1;
            if (m_left > 0) m_left <= m_left - 1;
        end
    end

    int           grant_log [$];
    logic [199:0] beats     [$];
    int           ixs       [$];
    logic [7:0]   tags      [$];
    int           run_len;
    int           max_run;

    task automatic check(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic compare_cycle();
        logic         e_push;
        int           e_ix;
        logic [199:0] e_dout;
        logic [7:0]   e_tag;
        logic [3:0]   e_ack;
        e_push = (m_left > 0);
        e_ix   = e_push ? 8 - m_left : 0;
        e_dout = e_push ? beat_val(m_core, e_ix) : '0;
        e_tag  = e_push ? tag_of(m_core) : 8'd0;
        e_ack  = (m_ack >= 0) ? 4'(1 << m_ack) : 4'b0000;
        n_checks++;
        if (ackout !== e_ack || pushout !== e_push || busy !== e_push ||
            doutix !== 3'(e_ix) || tagout !== e_tag || dout !== e_dout)
            $display("FAIL cycle_cmp t=%0t: ack=%b push=%b busy=%b ix=%0d tag=%h dout=%h required ack=%b push=%b ix=%0d tag=%h dout=%h",
                     $time, ackout, pushout, busy, doutix, tagout, dout, e_ack, e_push, e_ix, e_tag, e_dout);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        if (ackout != 4'b0000) begin
            for (int c = 0; c < 4; c++) if (ackout[c]) grant_log.push_back(c);
        end
        if (pushout) begin
            beats.push_back(dout);
            ixs.push_back(int'(doutix));
            tags.push_back(tagout);
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        for (int c = 0; c < 4; c++) if (ackout[c] && !sticky[c]) reqin[c] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        beats.delete();
        ixs.delete();
        tags.delete();
        run_len = 0;
        max_run = 0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        reqin  = 4'b0000;
        sticky = 4'b0000;
        run(2);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic check_log(input string nm, input int exp_q [$]);
        check({nm, "_count"}, 200'(grant_log.size()), 200'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
            check(nm, 200'(grant_log[i]), 200'(exp_q[i]));
    endtask

    initial begin
        int base;
        bit hit;
        for (int c = 0; c < 4; c++) begin
            tagin[c] = tag_of(c);
            for (int k = 0; k < 8; k++) din[c][200*k +: 200] = beat_val(c, k);
        end
        rst_n  = 1'b0;
        reqin  = 4'b0000;
        sticky = 4'b0000;
        run_len = 0;
        max_run = 0;
        @(posedge clk);
        run(2);
        check("reset_ctrl", 200'({ackout, pushout, busy, doutix, tagout}), 200'(0));
        check("reset_dout", dout, 200'(0));
        rst_n = 1'b1;
        clear_logs();

        // Single block from core 0
        reqin = 4'b0001;
        run(12);
        check_log("single_grant", '{0});
        check("single_beats", 200'(beats.size()), 200'(8));
        for (int k = 0; k < 8 && k < beats.size(); k++) begin
            check("single_dout", beats[k], 200'(k + 1));
            check("single_ix", 200'(ixs[k]), 200'(k));
            check("single_tag", 200'(tags[k]), 200'(8'h5A));
        end
        check("single_idle", 200'({pushout, busy}), 200'(0));

        // Back-to-back: core 0 then core 1
        do_reset();
        reqin = 4'b0011;
        run(20);
        check_log("b2b_grant", '{0, 1});
        check("b2b_run", 200'(max_run), 200'(16));
        for (int i = 0; i < 16 && i < ixs.size(); i++)
            check("b2b_ix", 200'(ixs[i]), 200'(i % 8));

        // All four cores request and keep their requests high
        do_reset();
        sticky = 4'b1111;
        reqin  = 4'b1111;
        run(36);
        sticky = 4'b0000;
        reqin  = 4'b0000;
`ifdef OUTPUT_SCHEDULER_RR_EN
        check_log("hold_grant", '{0, 1, 2, 3, 0});
`else
        check_log("hold_grant", '{0, 0, 0, 0, 0});
`endif
        run(10);

        // A request that arrives in the middle of a block
        do_reset();
        reqin = 4'b0001;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (pushout && doutix == 3'd3) hit = 1;
        end
        check("mid_beat3_seen", 200'(hit), 200'(1));
        reqin[2] = 1'b1;
        run(20);
        check_log("mid_grant", '{0, 2});
        check("mid_run", 200'(max_run), 200'(16));

        // Reset in the middle of a block
        do_reset();
        reqin = 4'b0001;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (pushout && doutix == 3'd4) hit = 1;
        end
        check("rst_beat4_seen", 200'(hit), 200'(1));
        #2;
        rst_n = 1'b0;
        reqin = 4'b0000;
        #1;
        check("async_rst_ctrl", 200'({ackout, pushout, busy, doutix, tagout}), 200'(0));
        check("async_rst_dout", dout, 200'(0));
        run(2);
        rst_n = 1'b1;
        base = grant_log.size();
        run(4);
        check("post_rst_idle", 200'({pushout, busy, ackout}), 200'(0));
        reqin = 4'b1000;
        run(12);
        check("post_rst_grants", 200'(grant_log.size() - base), 200'(1));
        if (grant_log.size() > base) check("post_rst_core", 200'(grant_log[base]), 200'(3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
